// File: rtl/hdmi_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_timing_pkg
//  Description : Shared types and helpers for the HDMI video timing controller
//                (stream lock state, raster total and counter width helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package hdmi_timing_pkg;

    // Stream lock state: SEEK hunts for a start-of-frame beat, RUN displays it
    typedef enum logic [0:0] {
        ST_SEEK = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Total length of one line or one frame from its four regions
    function automatic int calc_total(input int act, input int fp,
                                      input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Counter width needed to hold 0..total-1
    function automatic int calc_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_video_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_video_timing_ctrl_if
//  Description : AXI4-Stream video bundle (tuser = SOF, tlast = EOL).
//  Revision    : 1.0 - initial release
// ============================================================================
interface hdmi_video_timing_ctrl_if;

    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast,
                    input  tready);
    modport slave  (input  tdata, input  tvalid, input  tuser, input  tlast,
                    output tready);

endinterface
`default_nettype wire

// File: rtl/hdmi_timing_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_timing_cnt
//  Description : Free-running h/v raster counters with region decode.
//                Decode outputs describe the current (registered) count.
//                HDMI_TIMING_TEST_PATTERN_EN adds the colour-bar index.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdmi_timing_cnt
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36
) (
    input  wire logic clk,
    input  wire logic rst,
    output logic      o_active,
    output logic      o_hsync_on,
    output logic      o_vsync_on,
    output logic      o_origin,
    output logic      o_eol
`ifdef HDMI_TIMING_TEST_PATTERN_EN
    ,
    output logic [2:0] o_bar_idx
`endif
);

    localparam int c_h_total = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_h_w     = calc_width(c_h_total);
    localparam int c_v_w     = calc_width(c_v_total);

    localparam logic [c_h_w-1:0] c_h_last     = c_h_w'(c_h_total - 1);
    localparam logic [c_v_w-1:0] c_v_last     = c_v_w'(c_v_total - 1);
    localparam logic [c_h_w-1:0] c_h_act      = c_h_w'(H_ACTIVE);
    localparam logic [c_v_w-1:0] c_v_act      = c_v_w'(V_ACTIVE);
    localparam logic [c_h_w-1:0] c_h_eol      = c_h_w'(H_ACTIVE - 1);
    localparam logic [c_h_w-1:0] c_hs_start   = c_h_w'(H_ACTIVE + H_FP);
    localparam logic [c_h_w-1:0] c_hs_end     = c_h_w'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_v_w-1:0] c_vs_start   = c_v_w'(V_ACTIVE + V_FP);
    localparam logic [c_v_w-1:0] c_vs_end     = c_v_w'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_h_w-1:0] r_h_cnt;
    logic [c_v_w-1:0] r_v_cnt;

    // Raster scan: h wraps every line and advances v, v wraps every frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + c_v_w'(1);
        end else begin
            r_h_cnt <= r_h_cnt + c_h_w'(1);
        end
    end

    assign o_active   = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign o_hsync_on = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    assign o_vsync_on = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
    assign o_origin   = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_eol      = (r_h_cnt == c_h_eol);

`ifdef HDMI_TIMING_TEST_PATTERN_EN
    // Eight equal bars across the active width; any remainder joins the last bar
    localparam int c_bar_w = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [c_h_w-1:0] w_bar_q;
    assign w_bar_q   = r_h_cnt / c_h_w'(c_bar_w);
    assign o_bar_idx = (w_bar_q > c_h_w'(7)) ? 3'd7 : w_bar_q[2:0];
`endif

endmodule
`default_nettype wire

// File: rtl/hdmi_video_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_video_timing_ctrl
//  Description : HDMI transmit sequencer. Generates CEA-style raster timing,
//                pulls AXI4-Stream video during the active region, locks
//                stream frames to the raster origin and flags underrun and
//                framing loss. Outputs are registered one cycle behind the
//                raster counters.
//                Optional build macro HDMI_TIMING_TEST_PATTERN_EN adds
//                pattern_en_i, which replaces the stream with colour bars.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdmi_video_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int   PX_WIDTH = 10,
    parameter int   H_ACTIVE = 1920,
    parameter int   H_FP     = 88,
    parameter int   H_SYNC   = 44,
    parameter int   H_BP     = 148,
    parameter int   V_ACTIVE = 1080,
    parameter int   V_FP     = 4,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 36,
    parameter logic SYNC_POL = 1'b1
) (
    input  wire logic                    px_clk_i,
    input  wire logic                    rst_i,
    hdmi_video_timing_ctrl_if.slave      video_i,
`ifdef HDMI_TIMING_TEST_PATTERN_EN
    input  wire logic                    pattern_en_i,
`endif
    output logic [3*PX_WIDTH-1:0]        px_data_o,
    output logic                         de_o,
    output logic                         hsync_o,
    output logic                         vsync_o,
    output logic                         underrun_o,
    output logic                         sync_lost_o
);

    logic   w_active;
    logic   w_hsync_on;
    logic   w_vsync_on;
    logic   w_origin;
    logic   w_eol;
    state_t r_state;
    state_t w_next_state;
    logic   w_tready;
    logic   w_underrun;
    logic   w_sync_lost;
    logic [3*PX_WIDTH-1:0] w_pix;

`ifdef HDMI_TIMING_TEST_PATTERN_EN
    logic [2:0]            w_bar_idx;
    logic [3*PX_WIDTH-1:0] w_bar_pix;
`endif

    hdmi_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_cnt (
        .clk        (px_clk_i),
        .rst        (rst_i),
        .o_active   (w_active),
        .o_hsync_on (w_hsync_on),
        .o_vsync_on (w_vsync_on),
        .o_origin   (w_origin),
        .o_eol      (w_eol)
`ifdef HDMI_TIMING_TEST_PATTERN_EN
        ,
        .o_bar_idx  (w_bar_idx)
`endif
    );

`ifdef HDMI_TIMING_TEST_PATTERN_EN
    // Bar order white..black maps to ch2=R, ch1=G, ch0=B full scale
    assign w_bar_pix = {{PX_WIDTH{~w_bar_idx[1]}},
                        {PX_WIDTH{~w_bar_idx[2]}},
                        {PX_WIDTH{~w_bar_idx[0]}}};
`endif

    // Tdata bits above the three channels carry nothing
    generate
        if (3 * PX_WIDTH < 32) begin : g_unused_tdata
            logic w_unused_tdata;
            assign w_unused_tdata = ^video_i.tdata[31:3*PX_WIDTH];
        end
    endgenerate

    // Lock FSM: handshake, pixel selection, underrun and framing checks
    always_comb begin
        w_tready     = 1'b0;
        w_next_state = r_state;
        w_pix        = '0;
        w_underrun   = 1'b0;
        w_sync_lost  = 1'b0;
`ifdef HDMI_TIMING_TEST_PATTERN_EN
        if (pattern_en_i) begin
            w_next_state = ST_SEEK;
            if (w_active) begin
                w_pix = w_bar_pix;
            end
        end else
`endif
        begin
            case (r_state)
                ST_SEEK: begin
                    // Flush anything that is not SOF; hold SOF until the origin
                    w_tready = video_i.tvalid && (!video_i.tuser || w_origin);
                    if (video_i.tvalid && video_i.tuser && w_origin) begin
                        w_next_state = ST_RUN;
                        w_pix        = video_i.tdata[3*PX_WIDTH-1:0];
                    end
                end
                ST_RUN: begin
                    w_tready = w_active;
                    if (w_active) begin
                        if (video_i.tvalid) begin
                            w_pix = video_i.tdata[3*PX_WIDTH-1:0];
                            if ((video_i.tuser != w_origin) ||
                                (video_i.tlast != w_eol)) begin
                                w_sync_lost  = 1'b1;
                                w_next_state = ST_SEEK;
                            end
                        end else begin
                            w_underrun = 1'b1;
                        end
                    end
                end
                default: begin
                    w_next_state = ST_SEEK;
                end
            endcase
        end
    end

    assign video_i.tready = w_tready;

    // Output stage and state register, one cycle behind the counters
    always_ff @(posedge px_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_SEEK;
            px_data_o   <= '0;
            de_o        <= 1'b0;
            hsync_o     <= ~SYNC_POL;
            vsync_o     <= ~SYNC_POL;
            underrun_o  <= 1'b0;
            sync_lost_o <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            px_data_o   <= w_pix;
            de_o        <= w_active;
            hsync_o     <= w_hsync_on ? SYNC_POL : ~SYNC_POL;
            vsync_o     <= w_vsync_on ? SYNC_POL : ~SYNC_POL;
            underrun_o  <= w_underrun;
            sync_lost_o <= w_sync_lost;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_video_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdmi_video_timing_ctrl
//  Description : Self-checking bench for hdmi_video_timing_ctrl on a small
//                raster (H 8/2/2/2, V 4/1/1/1). A behavioural model works from
//                the frame cycle index and a lock flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hdmi_video_timing_ctrl;

    localparam int P   = 10;
    localparam int HA  = 8;
    localparam int HF  = 2;
    localparam int HS  = 2;
    localparam int HB  = 2;
    localparam int VA  = 4;
    localparam int VF  = 1;
    localparam int VS  = 1;
    localparam int VB  = 1;
    localparam int HT  = HA + HF + HS + HB;   // 14
    localparam int VT  = VA + VF + VS + VB;   // 7
    localparam int FT  = HT * VT;             // 98 cycles per frame
    localparam int NPX = HA * VA;             // 32 beats per frame

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdmi_video_timing_ctrl_if vif ();

    logic [3*P-1:0] px;
    logic           de, hs, vs, ur, sl;

`ifdef HDMI_TIMING_TEST_PATTERN_EN
    logic pat = 1'b0;
`endif

    hdmi_video_timing_ctrl #(
        .PX_WIDTH (P),
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b1)
    ) dut (
        .px_clk_i    (clk),
        .rst_i       (rst),
        .video_i     (vif),
`ifdef HDMI_TIMING_TEST_PATTERN_EN
        .pattern_en_i(pat),
`endif
        .px_data_o   (px),
        .de_o        (de),
        .hsync_o     (hs),
        .vsync_o     (vs),
        .underrun_o  (ur),
        .sync_lost_o (sl)
    );

    int vectors     = 0;
    int miscompares = 0;

    // model state
    int t    = 0;
    bit lock = 1'b0;

    // source controls
    bit src_on        = 1'b0;
    int src_k         = 0;
    int drop_pct      = 0;
    int drop_burst    = 0;
    bit inject_tlast  = 1'b0;
    bit junk          = 1'b0;

    // observed event counters per phase
    int n_hs, n_vs, n_de, n_ur, n_sl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic clr_counts();
        n_hs = 0; n_vs = 0; n_de = 0; n_ur = 0; n_sl = 0;
    endtask

    // One pixel clock: drive a beat, check tready, then check registered outputs
    task automatic step();
        int          h, v;
        bit          act, org, eol, tv, tu, tl, etr, acc, shown;
        bit          e_ur, e_sl, e_de, e_hs, e_vs;
        logic [31:0] d;
        logic [3*P-1:0] e_px;

        @(negedge clk);
        h   = t % HT;
        v   = (t / HT) % VT;
        act = (h < HA) && (v < VA);
        org = (t % FT) == 0;
        eol = (h == HA - 1);

        d = $urandom;
        if (junk) begin
            tv = ($urandom_range(0, 3) != 0);
            tu = ($urandom_range(0, 15) == 0);
            tl = ($urandom_range(0, 7) == 0);
        end else begin
            tv = src_on;
            if (src_on && drop_burst > 0 && lock && act) begin
                tv = 1'b0;
                drop_burst--;
            end else if (drop_pct > 0 && $urandom_range(0, 99) < drop_pct) begin
                tv = 1'b0;
            end
            tu = (src_k == 0);
            tl = (src_k % HA) == HA - 1;
            if (inject_tlast && lock && tv && src_k == 5) begin
                tl           = 1'b1;
                inject_tlast = 1'b0;
            end
        end
        vif.tdata  = d;
        vif.tvalid = tv;
        vif.tuser  = tu;
        vif.tlast  = tl;

        etr = lock ? act : (tv && (!tu || org));
        #1;
        chk("tready", {31'd0, vif.tready}, {31'd0, etr});

        acc   = tv && etr;
        shown = acc && (lock || (tu && org));
        e_px  = shown ? d[3*P-1:0] : '0;
        e_ur  = lock && act && !tv;
        e_sl  = lock && acc && ((tu != org) || (tl != eol));
        e_de  = act;
        e_hs  = (h >= HA + HF) && (h < HA + HF + HS);
        e_vs  = (v >= VA + VF) && (v < VA + VF + VS);
        if (lock) lock = !e_sl;
        else      lock = acc && tu && org;
        if (acc && !junk) src_k = (src_k + 1) % NPX;

        @(posedge clk);
        #1;
        chk("px_data", {2'b0, px}, {2'b0, e_px});
        chk("de",        {31'd0, de}, {31'd0, e_de});
        chk("hsync",     {31'd0, hs}, {31'd0, e_hs});
        chk("vsync",     {31'd0, vs}, {31'd0, e_vs});
        chk("underrun",  {31'd0, ur}, {31'd0, e_ur});
        chk("sync_lost", {31'd0, sl}, {31'd0, e_sl});
        n_hs += int'(hs);
        n_vs += int'(vs);
        n_de += int'(de);
        n_ur += int'(ur);
        n_sl += int'(sl);
        t++;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_px"},     {2'b0, px},  32'd0);
        chk({tag, "_de"},     {31'd0, de}, 32'd0);
        chk({tag, "_hsync"},  {31'd0, hs}, 32'd0);
        chk({tag, "_vsync"},  {31'd0, vs}, 32'd0);
        chk({tag, "_ur"},     {31'd0, ur}, 32'd0);
        chk({tag, "_sl"},     {31'd0, sl}, 32'd0);
        chk({tag, "_tready"}, {31'd0, vif.tready}, 32'd0);
    endtask

    initial begin
        vif.tdata  = '0;
        vif.tvalid = 1'b0;
        vif.tuser  = 1'b0;
        vif.tlast  = 1'b0;

        // Reset held across clock edges
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst = 1'b0;
        t = 0; lock = 1'b0;

        // Idle raster, no stream
        clr_counts();
        repeat (2 * FT) step();
        chk("idle_hsync_cycles", n_hs, 2 * HS * VT);
        chk("idle_vsync_cycles", n_vs, 2 * VS * HT);
        chk("idle_de_cycles",    n_de, 2 * NPX);
        chk("idle_underruns",    n_ur, 0);

        // Continuous valid frames from the origin
        src_on = 1'b1; src_k = 0;
        clr_counts();
        repeat (3 * FT) step();
        chk("stream_underruns", n_ur, 0);
        chk("stream_sync_lost", n_sl, 0);
        chk("stream_de_cycles", n_de, 3 * NPX);

        // Asynchronous reset in the middle of an active line
        repeat (3) step();
        #2;
        vif.tvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_values("midline_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0; lock = 1'b0;

        // Stream resumes mid-frame with non-SOF beats
        src_k = 13;
        clr_counts();
        repeat (2 * FT) step();
        chk("midframe_underruns", n_ur, 0);
        chk("midframe_sync_lost", n_sl, 0);

        // Three dropped active beats while locked
        clr_counts();
        drop_burst = 3;
        repeat (FT) step();
        chk("drop3_underruns", n_ur, 3);
        repeat (FT) step();

        // Early tlast at pixel 5, then relock on the next frame
        clr_counts();
        inject_tlast = 1'b1;
        repeat (2 * FT) step();
        chk("early_tlast_sync_lost", n_sl, 1);
        chk("early_tlast_underruns", n_ur, 0);

        // Random valid gaps
        drop_pct = 20;
        repeat (3 * FT) step();
        drop_pct = 0;

        // Random beats with arbitrary framing flags
        junk = 1'b1;
        repeat (2 * FT) step();
        junk = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
